// File: rtl/fetch_issue_pkg.sv
// Shared definitions for the fetch stage: widths, reset PC, opcode constants
// and the fetch FSM state encoding.
package fetch_issue_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;
  localparam int OP_W    = 5;

  localparam logic [PC_W-1:0] RESET_PC = 16'h0000;
  localparam logic [OP_W-1:0] OP_HALT  = 5'b00000;
  localparam logic [OP_W-1:0] OP_NOP   = 5'b00001;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } fetchState_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched {instr, pc+2} while IF/ID is stalled.
module fetch_skid
  import fetch_issue_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               push,
  input  logic               pop,
  input  logic [INSTR_W-1:0] pushInstr,
  input  logic [PC_W-1:0]    pushPc2,
  output logic               full,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc2
);

  // push together with pop replaces the entry and the buffer stays full
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full  <= 1'b0;
      instr <= '0;
      pc2   <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (push) begin
      full  <= 1'b1;
      instr <= pushInstr;
      pc2   <= pushPc2;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_issue.sv
// Fetch stage: owns the PC, requests instructions from imem and fills the
// IF/ID register, with redirect flush/drain and HALT stop.
module fetch_issue
  import fetch_issue_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_done,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               id_stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [OP_W-1:0]    if_opcode,
  output logic [PC_W-1:0]    if_pc2,
  output logic               halted,
  output logic               err,
  output fetchState_t        dbgState
);

  // Handshakes: an imem request holds req and addr from the cycle it rises
  // until imem_done (done may arrive in the request cycle itself); IF/ID
  // transfers to decode on every edge where if_valid is high and id_stall low.

  fetchState_t state, stateNext;

  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    reqAddr;
  logic               reqPending;
  logic [PC_W-1:0]    addrPc2;
  logic               ifFree;
  logic               accept;
  logic               loadNew;
  logic               loadSkid;
  logic               pushSkid;
  logic               skidFull;
  logic [INSTR_W-1:0] skidInstr;
  logic [PC_W-1:0]    skidPc2;

  // reset gates req so an in-flight request is dropped the moment rst falls
  assign imem_req  = rst & (reqPending | ((state == ST_FETCH) & ~skidFull));
  assign imem_addr = reqPending ? reqAddr : pc;
  assign addrPc2   = imem_addr + PC_W'(2);

  assign ifFree   = ~if_valid | ~id_stall;
  assign accept   = imem_req & imem_done & (state == ST_FETCH) & ~redirect;
  assign loadSkid = skidFull & ifFree & ~redirect;
  assign loadNew  = accept & ifFree & ~skidFull;
  assign pushSkid = accept & ~loadNew;

  always_comb begin
    stateNext = state;
    case (state)
      ST_FETCH: begin
        if (redirect) begin
          stateNext = (imem_req & ~imem_done) ? ST_DRAIN : ST_FETCH;
        end else if (accept && (imem_data[INSTR_W-1 -: OP_W] == OP_HALT)) begin
          stateNext = ST_HALTED;
        end
      end
      ST_DRAIN: begin
        if (imem_done) stateNext = ST_FETCH;
      end
      ST_HALTED: begin
        if (redirect) stateNext = ST_FETCH;
      end
      default: stateNext = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      reqAddr    <= RESET_PC;
      reqPending <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= stateNext;
      reqAddr    <= imem_addr;
      reqPending <= imem_req & ~imem_done;
      if (redirect) begin
        pc <= redirect_pc;
      end else if (accept) begin
        pc <= pc + PC_W'(2);
      end
      if (redirect & redirect_pc[0]) err <= 1'b1;
    end
  end

  // the skid entry is older than any new response, so it enters IF/ID first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc2   <= '0;
    end else if (redirect) begin
      if_valid <= 1'b0;
    end else if (loadSkid) begin
      if_valid <= 1'b1;
      if_instr <= skidInstr;
      if_pc2   <= skidPc2;
    end else if (loadNew) begin
      if_valid <= 1'b1;
      if_instr <= imem_data;
      if_pc2   <= addrPc2;
    end else if (ifFree) begin
      if_valid <= 1'b0;
    end
  end

  fetch_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (pushSkid),
    .pop       (loadSkid),
    .pushInstr (imem_data),
    .pushPc2   (addrPc2),
    .full      (skidFull),
    .instr     (skidInstr),
    .pc2       (skidPc2)
  );

  assign if_opcode = if_instr[INSTR_W-1 -: OP_W];
  assign halted    = (state == ST_HALTED);
  assign dbgState  = state;

endmodule

// File: tb/tb_fetch_issue.sv
// Bench for fetch_issue: behavioural imem with configurable latency and a
// stream model of which instruction decode must see next.
module tb_fetch_issue;
  import fetch_issue_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_done;
  logic [INSTR_W-1:0] imem_data;
  logic               id_stall;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [OP_W-1:0]    if_opcode;
  logic [PC_W-1:0]    if_pc2;
  logic               halted;
  logic               err;
  fetchState_t        dbgState;

  int checks = 0;
  int errors = 0;

  logic [INSTR_W-1:0] mem [0:255];
  int lat = 1;
  int waitCnt = 0;

  always #5 clk = ~clk;

  fetch_issue dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_done   (imem_done),
    .imem_data   (imem_data),
    .id_stall    (id_stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_opcode   (if_opcode),
    .if_pc2      (if_pc2),
    .halted      (halted),
    .err         (err),
    .dbgState    (dbgState)
  );

  // imem answers lat cycles after req rises; lat==1 answers in the request cycle
  assign imem_done = imem_req && (waitCnt >= lat - 1);
  assign imem_data = mem[imem_addr[8:1]];

  always @(posedge clk or negedge rst) begin
    if (!rst) waitCnt <= 0;
    else if (imem_req && !imem_done) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  function automatic logic [INSTR_W-1:0] rand_instr();
    logic [OP_W-1:0] op;
    logic [10:0] lo;
    op = OP_W'($urandom_range(1, 31));
    lo = 11'($urandom);
    return {op, lo};
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = rand_instr();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    id_stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    lat = 1;
    rst = 1'b0;
    id_stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    @(negedge clk);
    #1;
    checks++;
    if ({imem_req, if_valid, halted, err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got req/valid/halted/err=%b expected 0000",
               {imem_req, if_valid, halted, err});
    end
    checks++;
    if (if_instr !== '0 || if_opcode !== '0 || if_pc2 !== '0) begin
      errors++;
      $display("FAIL reset_ifid: got instr=%h op=%h pc2=%h expected all 0", if_instr, if_opcode, if_pc2);
    end
    checks++;
    if (dbgState !== ST_FETCH || imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_state: got state=%0d addr=%h expected FETCH addr=%h", dbgState, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_nop_stream();
    lat = 1;
    fill_mem();
    for (int i = 0; i < 4; i++) mem[i] = {OP_NOP, 11'(i)};
    apply_reset();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || if_pc2 !== PC_W'(2 * k) || if_instr !== mem[k-1]) begin
        errors++;
        $display("FAIL nop_stream_%0d: got valid=%b pc2=%h instr=%h expected 1 %h %h",
                 k, if_valid, if_pc2, if_instr, PC_W'(2 * k), mem[k-1]);
      end
    end
  endtask

  // Random stream: model tracks the next address to fetch, the next instruction
  // decode must see, and how many fetched instructions are still buffered.
  task automatic test_stream(input string name, input int latency, input int cycles,
                             input int stallPct, input int redirPct, input int forceAt);
    logic [PC_W-1:0] expPc, fetchPc, rpc, prevAddr;
    int occ, consumed;
    bit drop, prevPend, stall, redir, respond;
    lat = latency;
    fill_mem();
    apply_reset();
    expPc = RESET_PC;
    fetchPc = RESET_PC;
    occ = 0;
    consumed = 0;
    drop = 0;
    prevPend = 0;
    prevAddr = '0;
    for (int c = 0; c < cycles; c++) begin
      checks++;
      if (if_valid !== (occ > 0)) begin
        errors++;
        $display("FAIL %s_valid c%0d: got %b expected %b", name, c, if_valid, occ > 0);
      end
      if (occ > 0) begin
        checks++;
        if (if_pc2 !== expPc + PC_W'(2) || if_instr !== mem[expPc[8:1]]) begin
          errors++;
          $display("FAIL %s_ifid c%0d: got pc2=%h instr=%h expected %h %h",
                   name, c, if_pc2, if_instr, expPc + PC_W'(2), mem[expPc[8:1]]);
        end
      end
      if (occ == 2) begin
        checks++;
        if (imem_req !== 1'b0) begin
          errors++;
          $display("FAIL %s_req_full c%0d: got req=%b expected 0", name, c, imem_req);
        end
      end
      if (prevPend) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== prevAddr) begin
          errors++;
          $display("FAIL %s_hold c%0d: got req=%b addr=%h expected 1 %h", name, c, imem_req, imem_addr, prevAddr);
        end
      end
      if (imem_req && !drop) begin
        checks++;
        if (imem_addr !== fetchPc) begin
          errors++;
          $display("FAIL %s_addr c%0d: got %h expected %h", name, c, imem_addr, fetchPc);
        end
      end
      checks++;
      if (err !== 1'b0) begin
        errors++;
        $display("FAIL %s_err c%0d: got %b expected 0", name, c, err);
      end
      if (c == forceAt + 2 && lat == 1) begin
        checks++;
        if (imem_req !== 1'b0 || occ != 2) begin
          errors++;
          $display("FAIL %s_skid_fill: got req=%b occupancy=%0d expected 0 2", name, imem_req, occ);
        end
      end

      stall = ($urandom_range(0, 99) < stallPct);
      if (c >= forceAt && c < forceAt + 3) stall = 1;
      redir = (c > 5) && ($urandom_range(0, 99) < redirPct);
      rpc = {7'd0, 8'($urandom), 1'b0};
      id_stall = stall;
      redirect = redir;
      redirect_pc = rpc;

      respond = imem_req && imem_done;
      prevPend = imem_req && !imem_done;
      prevAddr = imem_addr;
      if (redir) begin
        occ = 0;
        expPc = rpc;
        fetchPc = rpc;
        drop = imem_req && !imem_done;
      end else begin
        if (respond && drop) begin
          drop = 0;
        end else if (respond) begin
          occ++;
          fetchPc = fetchPc + PC_W'(2);
        end
        if (occ > 0 && !(occ == 1 && respond && !drop && if_valid !== 1'b1) && !stall && if_valid === 1'b1) begin
          occ--;
          consumed++;
          expPc = expPc + PC_W'(2);
        end
      end
      @(negedge clk);
    end
    id_stall = 1'b0;
    redirect = 1'b0;
    checks++;
    if (consumed < cycles / 12) begin
      errors++;
      $display("FAIL %s_progress: got %0d instructions expected at least %0d", name, consumed, cycles / 12);
    end
  endtask

  task automatic test_redirect_drain();
    bit seen;
    lat = 3;
    fill_mem();
    apply_reset();
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (dbgState !== ST_DRAIN || imem_req !== 1'b1 || imem_addr !== 16'h0000 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_enter: got state=%0d req=%b addr=%h valid=%b expected DRAIN 1 0000 0",
               dbgState, imem_req, imem_addr, if_valid);
    end
    seen = 0;
    for (int i = 0; i < 15 && !seen; i++) begin
      @(negedge clk);
      if (if_valid === 1'b1) begin
        seen = 1;
        checks++;
        if (if_pc2 !== 16'h0042 || if_instr !== mem[8'h20]) begin
          errors++;
          $display("FAIL drain_first: got pc2=%h instr=%h expected 0042 %h", if_pc2, if_instr, mem[8'h20]);
        end
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got no valid instruction expected pc2 0042");
    end
  endtask

  task automatic test_redirect_same_cycle();
    lat = 1;
    fill_mem();
    apply_reset();
    repeat (3) @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 16'h0020;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || dbgState !== ST_FETCH || imem_addr !== 16'h0020) begin
      errors++;
      $display("FAIL same_cycle_flush: got valid=%b state=%0d addr=%h expected 0 FETCH 0020",
               if_valid, dbgState, imem_addr);
    end
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_pc2 !== 16'h0022 || if_instr !== mem[8'h10]) begin
      errors++;
      $display("FAIL same_cycle_next: got valid=%b pc2=%h expected 1 0022", if_valid, if_pc2);
    end
  endtask

  task automatic test_halt();
    lat = 1;
    fill_mem();
    for (int i = 0; i < 3; i++) mem[i] = {OP_NOP, 11'd0};
    mem[3] = 16'h0005;
    apply_reset();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || if_pc2 !== PC_W'(2 * k)) begin
        errors++;
        $display("FAIL halt_stream_%0d: got valid=%b pc2=%h expected 1 %h", k, if_valid, if_pc2, PC_W'(2 * k));
      end
    end
    checks++;
    if (if_opcode !== OP_HALT || halted !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL halt_present: got op=%h halted=%b req=%b expected 00 1 0", if_opcode, halted, imem_req);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || halted !== 1'b1 || if_valid !== 1'b0 || dbgState !== ST_HALTED) begin
        errors++;
        $display("FAIL halt_hold_%0d: got req=%b halted=%b valid=%b state=%0d expected 0 1 0 HALTED",
                 i, imem_req, halted, if_valid, dbgState);
      end
    end
    redirect = 1'b1;
    redirect_pc = 16'h0010;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
      errors++;
      $display("FAIL halt_resume: got halted=%b req=%b addr=%h expected 0 1 0010", halted, imem_req, imem_addr);
    end
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_pc2 !== 16'h0012 || if_instr !== mem[8'h08]) begin
      errors++;
      $display("FAIL halt_refetch: got valid=%b pc2=%h expected 1 0012", if_valid, if_pc2);
    end
  endtask

  task automatic test_err_and_reset();
    lat = 1;
    fill_mem();
    apply_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b expected 0", err);
    end
    redirect = 1'b1;
    redirect_pc = 16'h0013;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (err !== 1'b1 || imem_addr !== 16'h0013) begin
      errors++;
      $display("FAIL err_set: got err=%b addr=%h expected 1 0013", err, imem_addr);
    end
    redirect = 1'b1;
    redirect_pc = 16'h0020;
    @(negedge clk);
    redirect = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (err !== 1'b1) begin
        errors++;
        $display("FAIL err_sticky_%0d: got %b expected 1", i, err);
      end
    end
    lat = 3;
    repeat (2) @(negedge clk);
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL midfetch_req: got %b expected 1", imem_req);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({imem_req, if_valid, halted, err} !== 4'b0000 || if_instr !== '0 || if_pc2 !== '0 ||
        if_opcode !== '0 || imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL midfetch_reset: got req/valid/halted/err=%b instr=%h pc2=%h addr=%h expected all 0",
               {imem_req, if_valid, halted, err}, if_instr, if_pc2, imem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    test_reset();
    test_nop_stream();
    test_stream("stall", 1, 40, 0, 0, 10);
    test_redirect_drain();
    test_redirect_same_cycle();
    test_halt();
    test_err_and_reset();
    test_stream("rand_lat1", 1, 300, 30, 5, -10);
    test_stream("rand_lat2", 2, 300, 30, 5, -10);
    test_stream("rand_lat3", 3, 300, 25, 4, -10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
